simple_fifo_ex: RTL and testbench

Parametrised successor to the team's single-clock simple FIFO. Adds a selectable show-ahead (first-word-fall-through) mode, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush, and a correctly sized occupancy count. Used as the general buffering element between synthesised datapath stages and stream interfaces.

---
 rtl/simple_fifo_ex.sv | 96 +++++++++
 tb/tb_simple_fifo_ex.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/simple_fifo_ex.sv
// Single-clock synchronous FIFO with selectable show-ahead read, programmable
// almost-full/almost-empty thresholds, sticky error flags and a synchronous flush.
module simple_fifo_ex #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 8,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             we,
  input  logic [WIDTH-1:0] din,
  input  logic             re,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic             overflow,
  output logic             underflow,
  output logic [CW-1:0]    count
);

  localparam int PW = $clog2(DEPTH);

  if (WIDTH < 1 || DEPTH < 2 || (FWFT != 0 && FWFT != 1) ||
      AF_LEVEL < 1 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_param
    $error("simple_fifo_ex: illegal parameter combination");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             rd_ok;
  logic             wr_ok;

  // Request semantics: we/re are one-cycle requests sampled at the rising edge.
  // A read is accepted whenever the FIFO holds data; a write is accepted when
  // there is space or when an accepted read in the same cycle frees a slot.
  // Rejected requests only raise the sticky error flags; clr overrides both.
  assign rd_ok = re && (count != '0);
  assign wr_ok = we && ((count != CW'(DEPTH)) || rd_ok);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (we && !wr_ok)         overflow  <= 1'b1;
      if (re && (count == '0))  underflow <= 1'b1;
    end
  end

  // Storage is deliberately not reset; a flushed or reset FIFO simply ignores it.
  always_ff @(posedge clk) begin
    if (reset && !clr && wr_ok) mem[wr_ptr] <= din;
  end

  if (FWFT != 0) begin : g_fwft
    assign dout = mem[rd_ptr];
  end else begin : g_std
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)             dout <= '0;
      else if (rd_ok && !clr) dout <= mem[rd_ptr];
    end
  end

  assign empty        = (count == '0);
  assign full         = (count == CW'(DEPTH));
  assign almost_empty = (count <= CW'(AE_LEVEL));
  assign almost_full  = (count >= CW'(AF_LEVEL));

endmodule

// File: tb/tb_simple_fifo_ex.sv
// Bench for simple_fifo_ex: three instances (registered DEPTH=8, show-ahead
// DEPTH=8, registered DEPTH=5 with edge thresholds) share one stimulus stream.
module tb_simple_fifo_ex;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clr = 1'b0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [63:0] din = '0;

  logic [63:0] dout_a [3];
  logic        empty_a [3];
  logic        full_a [3];
  logic        ae_a [3];
  logic        af_a [3];
  logic        ovf_a [3];
  logic        unf_a [3];
  logic [3:0]  count0;
  logic [3:0]  count1;
  logic [2:0]  count2;

  int dep_c  [3] = '{8, 8, 5};
  int af_c   [3] = '{7, 7, 5};
  int ae_c   [3] = '{1, 1, 0};
  int fwft_c [3] = '{0, 1, 0};

  // Reference model: contents as a queue of words, plus the sticky flags
  logic [63:0] mq [3][$];
  logic [63:0] exp_q [3][$];
  logic [63:0] last_dout [3];
  logic        m_ovf [3];
  logic        m_unf [3];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  simple_fifo_ex #(.WIDTH(64), .DEPTH(8), .FWFT(0)) u0 (
    .clk(clk), .reset(reset), .clr(clr), .we(we), .din(din), .re(re),
    .dout(dout_a[0]), .empty(empty_a[0]), .full(full_a[0]),
    .almost_empty(ae_a[0]), .almost_full(af_a[0]),
    .overflow(ovf_a[0]), .underflow(unf_a[0]), .count(count0));

  simple_fifo_ex #(.WIDTH(64), .DEPTH(8), .FWFT(1)) u1 (
    .clk(clk), .reset(reset), .clr(clr), .we(we), .din(din), .re(re),
    .dout(dout_a[1]), .empty(empty_a[1]), .full(full_a[1]),
    .almost_empty(ae_a[1]), .almost_full(af_a[1]),
    .overflow(ovf_a[1]), .underflow(unf_a[1]), .count(count1));

  simple_fifo_ex #(.WIDTH(64), .DEPTH(5), .FWFT(0), .AF_LEVEL(5), .AE_LEVEL(0)) u2 (
    .clk(clk), .reset(reset), .clr(clr), .we(we), .din(din), .re(re),
    .dout(dout_a[2]), .empty(empty_a[2]), .full(full_a[2]),
    .almost_empty(ae_a[2]), .almost_full(af_a[2]),
    .overflow(ovf_a[2]), .underflow(unf_a[2]), .count(count2));

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      exp_q[i].delete();
      last_dout[i] = '0;
      m_ovf[i] = 1'b0;
      m_unf[i] = 1'b0;
    end
  endtask

  always @(negedge reset) model_clear();

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        if (clr) begin
          mq[i].delete();
          m_ovf[i] = 1'b0;
          m_unf[i] = 1'b0;
        end else begin
          int  sz;
          logic rd;
          logic wr;
          sz = mq[i].size();
          rd = re && (sz != 0);
          wr = we && ((sz != dep_c[i]) || rd);
          if (re && sz == 0) m_unf[i] = 1'b1;
          if (we && !wr)     m_ovf[i] = 1'b1;
          if (rd) exp_q[i].push_back(mq[i].pop_front());
          if (wr) mq[i].push_back(din);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    int cnt [3];
    cnt[0] = int'(count0);
    cnt[1] = int'(count1);
    cnt[2] = int'(count2);
    for (int i = 0; i < 3; i++) begin
      int sz;
      sz = mq[i].size();
      chk($sformatf("u%0d count", i), 64'(cnt[i]), 64'(sz));
      chk($sformatf("u%0d empty", i), 64'(empty_a[i]), 64'(sz == 0));
      chk($sformatf("u%0d full", i), 64'(full_a[i]), 64'(sz == dep_c[i]));
      chk($sformatf("u%0d almost_empty", i), 64'(ae_a[i]), 64'(sz <= ae_c[i]));
      chk($sformatf("u%0d almost_full", i), 64'(af_a[i]), 64'(sz >= af_c[i]));
      chk($sformatf("u%0d overflow", i), 64'(ovf_a[i]), 64'(m_ovf[i]));
      chk($sformatf("u%0d underflow", i), 64'(unf_a[i]), 64'(m_unf[i]));
      if (fwft_c[i] != 0) begin
        if (sz != 0) chk($sformatf("u%0d head", i), dout_a[i], mq[i][0]);
      end else begin
        if (exp_q[i].size() != 0) last_dout[i] = exp_q[i].pop_front();
        chk($sformatf("u%0d dout", i), dout_a[i], last_dout[i]);
      end
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk);
      #2;
      check_all();
    end
  end

  task automatic step(input logic w, input logic [63:0] d, input logic r, input logic c);
    @(negedge clk);
    we = w;
    din = d;
    re = r;
    clr = c;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 64'h0, 1'b0, 1'b0);
  endtask

  task automatic async_reset_check();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_all();
    we = 1'b0;
    re = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;
    check_all();

    // Fill 1..8, then one write too many
    for (int k = 1; k <= 9; k++) step(1'b1, 64'(k), 1'b0, 1'b0);
    // Drain, then read once more while empty
    for (int k = 0; k < 9; k++) step(1'b0, 64'h0, 1'b1, 1'b0);
    idle(2);

    // Refill, then simultaneous write/read at full, then drain across the wrap
    step(1'b0, 64'h0, 1'b0, 1'b1);
    for (int k = 1; k <= 8; k++) step(1'b1, 64'(k), 1'b0, 1'b0);
    for (int k = 9; k <= 12; k++) step(1'b1, 64'(k), 1'b1, 1'b0);
    for (int k = 0; k < 9; k++) step(1'b0, 64'h0, 1'b1, 1'b0);
    idle(1);

    // Show-ahead: lone word, pop, then write+read against an empty FIFO
    step(1'b0, 64'h0, 1'b0, 1'b1);
    step(1'b1, 64'hA5, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    idle(1);
    step(1'b1, 64'h5A, 1'b1, 1'b0);
    idle(2);

    // Flush with a concurrent write, then async reset with data held
    step(1'b0, 64'h0, 1'b0, 1'b1);
    for (int k = 0; k < 9; k++) step(1'b1, 64'h100 + 64'(k), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 64'h0, 1'b1, 1'b0);
    idle(1);
    step(1'b1, 64'hDEAD, 1'b0, 1'b1);
    idle(1);
    for (int k = 0; k < 3; k++) step(1'b1, 64'h200 + 64'(k), 1'b0, 1'b0);
    async_reset_check();
    idle(2);

    // Random traffic with write-heavy and read-heavy phases
    for (int k = 0; k < 400; k++) begin
      logic w;
      logic r;
      logic c;
      if ((k / 50) % 2 == 0) begin
        w = ($urandom_range(0, 99) < 70);
        r = ($urandom_range(0, 99) < 35);
      end else begin
        w = ($urandom_range(0, 99) < 35);
        r = ($urandom_range(0, 99) < 70);
      end
      c = ($urandom_range(0, 59) == 0);
      step(w, {$urandom, $urandom}, r, c);
    end
    idle(3);

    @(posedge clk);
    #4;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation exceeded time budget");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
